// File: rtl/fast_square_sweep_ctrl.sv
// Frequency-sweep sequencer for fast_square_bb receive channels: settle, record, advance.
// Optional build macro FAST_SQUARE_TIMESTAMP_EN adds a cycle-count timestamp of each RECORD start.
module fast_square_sweep_ctrl #(
  parameter int NUM_FREQ_STEPS = 32,
  parameter int STEP_W         = 6,
  parameter int TICK_W         = 16,
  parameter int NUM_CHAN       = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                continuous,
  input  logic [STEP_W-1:0]   num_steps,
  input  logic [TICK_W-1:0]   record_ticks,
  input  logic [TICK_W-1:0]   settle_ticks,
  input  logic [NUM_CHAN-1:0] chan_mask,
  input  logic                sync_in,
  output logic                freq_step_out,
  output logic [NUM_CHAN-1:0] rx_reset,
  output logic [NUM_CHAN-1:0] rx_next,
  output logic [NUM_CHAN-1:0] rx_record,
  output logic [STEP_W-1:0]   step_idx,
  output logic                busy,
  output logic                sweep_done,
  output logic [7:0]          sync_err,
  output logic [31:0]         rec_timestamp
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SETTLE, S_RECORD, S_NEXT, S_DONE} state_t;

  typedef struct packed {
    state_t            st;
    logic [TICK_W-1:0] tk;
  } entry_t;

  state_t                state_q, state_d;
  logic [STEP_W-1:0]     step_q, step_d, num_q, num_d, eff_steps;
  logic [TICK_W-1:0]     tick_q, tick_d, rec_q, rec_d, set_q, set_d;
  logic [NUM_CHAN-1:0]   mask_q, mask_d, act_mask;
  logic [7:0]            err_q, err_d;
  logic                  sync_q, sync_q_d, rise;
  logic                  resync, pulse_next, done_pulse, last_step;
  entry_t                ent;

  function automatic logic [TICK_W-1:0] rec_load(input logic [TICK_W-1:0] r);
    return (r == '0) ? '0 : r - TICK_W'(1);
  endfunction

  // Start of a step: SETTLE when a settle window exists, otherwise straight to RECORD.
  function automatic entry_t entry_of(input logic [TICK_W-1:0] s, input logic [TICK_W-1:0] r);
    entry_t e;
    if (s != '0) begin
      e.st = S_SETTLE;
      e.tk = s - TICK_W'(1);
    end else begin
      e.st = S_RECORD;
      e.tk = rec_load(r);
    end
    return e;
  endfunction

  assign rise      = sync_q & ~sync_q_d;
  assign eff_steps = ((num_q == '0) || (num_q > STEP_W'(NUM_FREQ_STEPS))) ?
                     STEP_W'(NUM_FREQ_STEPS) : num_q;
  assign last_step = (step_q == eff_steps - STEP_W'(1));

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tick_d     = tick_q;
    num_d      = num_q;
    rec_d      = rec_q;
    set_d      = set_q;
    mask_d     = mask_q;
    err_d      = err_q;
    ent        = entry_of(set_q, rec_q);
    resync     = 1'b0;
    pulse_next = 1'b0;
    done_pulse = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_ARM;
        S_ARM: begin
          if (rise) begin
            num_d   = num_steps;
            rec_d   = record_ticks;
            set_d   = settle_ticks;
            mask_d  = chan_mask;
            step_d  = '0;
            ent     = entry_of(settle_ticks, record_ticks);
            state_d = ent.st;
            tick_d  = ent.tk;
          end
        end
        S_SETTLE, S_RECORD, S_NEXT: begin
          if (rise) begin
            resync  = 1'b1;
            step_d  = '0;
            err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            state_d = ent.st;
            tick_d  = ent.tk;
          end else if (state_q == S_SETTLE) begin
            if (tick_q == '0) begin
              state_d = S_RECORD;
              tick_d  = rec_load(rec_q);
            end else begin
              tick_d = tick_q - TICK_W'(1);
            end
          end else if (state_q == S_RECORD) begin
            if (tick_q == '0) state_d = S_NEXT;
            else              tick_d  = tick_q - TICK_W'(1);
          end else begin
            pulse_next = 1'b1;
            if (!last_step) begin
              step_d  = step_q + STEP_W'(1);
              state_d = ent.st;
              tick_d  = ent.tk;
            end else begin
              done_pulse = 1'b1;
              if (continuous) begin
                num_d   = num_steps;
                rec_d   = record_ticks;
                set_d   = settle_ticks;
                mask_d  = chan_mask;
                step_d  = '0;
                ent     = entry_of(settle_ticks, record_ticks);
                state_d = ent.st;
                tick_d  = ent.tk;
              end else begin
                state_d = S_DONE;
              end
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments under the async active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      tick_q   <= '0;
      num_q    <= '0;
      rec_q    <= '0;
      set_q    <= '0;
      mask_q   <= '0;
      err_q    <= '0;
      sync_q   <= 1'b0;
      sync_q_d <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      tick_q   <= tick_d;
      num_q    <= num_d;
      rec_q    <= rec_d;
      set_q    <= set_d;
      mask_q   <= mask_d;
      err_q    <= err_d;
      sync_q   <= sync_in;
      sync_q_d <= sync_q;
    end
  end

  // Before the first latch the live mask decides which receivers are held in reset.
  assign act_mask      = ((state_q == S_IDLE) || (state_q == S_ARM)) ? chan_mask : mask_q;
  assign rx_reset      = ((state_q == S_IDLE) || (state_q == S_ARM) || resync) ? act_mask : '0;
  assign rx_record     = (enable && (state_q == S_RECORD)) ? mask_q : '0;
  assign rx_next       = pulse_next ? mask_q : '0;
  assign freq_step_out = pulse_next;
  assign sweep_done    = done_pulse;
  assign busy          = enable && ((state_q == S_SETTLE) || (state_q == S_RECORD) ||
                                    (state_q == S_NEXT));
  assign step_idx      = step_q;
  assign sync_err      = err_q;

`ifdef FAST_SQUARE_TIMESTAMP_EN
  logic [31:0] cyc_q, ts_q;
  logic        rec_start;

  assign rec_start = (state_d == S_RECORD) && ((state_q != S_RECORD) || resync);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q <= '0;
      ts_q  <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (rec_start) ts_q <= cyc_q + 32'd1;
    end
  end

  assign rec_timestamp = ts_q;
`else
  assign rec_timestamp = '0;
`endif

endmodule

// File: tb/tb_fast_square_sweep_ctrl.sv
// Directed bench for fast_square_sweep_ctrl: sweep timing, wrap, re-sync, mask/clamp, abort, timestamp.
module tb_fast_square_sweep_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        continuous;
  logic [5:0]  num_steps;
  logic [15:0] record_ticks;
  logic [15:0] settle_ticks;
  logic [1:0]  chan_mask;
  logic        sync_in;
  logic        freq_step_out;
  logic [1:0]  rx_reset;
  logic [1:0]  rx_next;
  logic [1:0]  rx_record;
  logic [5:0]  step_idx;
  logic        busy;
  logic        sweep_done;
  logic [7:0]  sync_err;
  logic [31:0] rec_timestamp;

  int vectors = 0;
  int miscompares = 0;

  fast_square_sweep_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .continuous   (continuous),
    .num_steps    (num_steps),
    .record_ticks (record_ticks),
    .settle_ticks (settle_ticks),
    .chan_mask    (chan_mask),
    .sync_in      (sync_in),
    .freq_step_out(freq_step_out),
    .rx_reset     (rx_reset),
    .rx_next      (rx_next),
    .rx_record    (rx_record),
    .step_idx     (step_idx),
    .busy         (busy),
    .sweep_done   (sweep_done),
    .sync_err     (sync_err),
    .rec_timestamp(rec_timestamp)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  int nk[$];
  int ns[$];
  int dk[$];
  int ts[$];
  int first_rec, rec_cycles, bad_bit1, max_step, extra_pulses;
  logic [1:0] prev_rec;

  initial begin
    reset_n = 1'b0; enable = 1'b0; continuous = 1'b0; num_steps = '0;
    record_ticks = '0; settle_ticks = '0; chan_mask = 2'b11; sync_in = 1'b0;
    #1;
    check("rst rx_reset", rx_reset, 2'b11);
    check("rst busy", busy, 1'b0);
    check("rst step_idx", step_idx, 6'd0);
    check("rst sync_err", sync_err, 8'd0);
    check("rst rx_next|rx_record", {rx_next, rx_record}, 4'd0);
    check("rst pulses", {freq_step_out, sweep_done}, 2'd0);
    check("rst rec_timestamp", rec_timestamp, 32'd0);
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();

    // Single sweep: 4 steps, settle 3, record 5.
    num_steps = 6'd4; settle_ticks = 16'd3; record_ticks = 16'd5; continuous = 1'b0;
    enable = 1'b1;
    cyc();
    check("t1 arm rx_reset", rx_reset, 2'b11);
    check("t1 arm busy", busy, 1'b0);
    sync_in = 1'b1;
    first_rec = -1; rec_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      if (freq_step_out) begin
        nk.push_back(k); ns.push_back(int'(step_idx));
        check($sformatf("t1 rx_next k%0d", k), rx_next, 2'b11);
      end
      if (sweep_done) dk.push_back(k);
      if (rx_record != 2'b00) begin
        rec_cycles++;
        if (first_rec < 0) first_rec = k;
      end
      if (k == 1) check("t1 rise rx_reset", rx_reset, 2'b11);
      if (k == 2) check("t1 settle rx_reset/busy", {rx_reset, busy}, 3'b001);
    end
    check("t1 first record", first_rec, 5);
    check("t1 record cycles", rec_cycles, 20);
    check("t1 next count", nk.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1 next_k[%0d]", i), (i < nk.size()) ? nk[i] : -1, 10 + 9 * i);
      check($sformatf("t1 next_step[%0d]", i), (i < ns.size()) ? ns[i] : -1, i);
    end
    check("t1 done count", dk.size(), 1);
    check("t1 done k", (dk.size() > 0) ? dk[0] : -1, 37);
    check("t1 done busy", busy, 1'b0);
    check("t1 done step_idx", step_idx, 6'd3);

    // Rise in DONE is ignored.
    sync_in = 1'b0; cyc(); cyc();
    sync_in = 1'b1; cyc();
    check("t1 done rise pulses", {rx_next, freq_step_out, busy}, 4'd0);
    cyc();
    check("t1 done rise sync_err", sync_err, 8'd0);
    check("t1 done rise step_idx", step_idx, 6'd3);
    enable = 1'b0;
    cyc();
    check("t1 idle rx_reset", rx_reset, 2'b11);
    check("t1 idle step held", step_idx, 6'd3);

    // Continuous wrap: 2 steps, settle 0, record 1.
    num_steps = 6'd2; settle_ticks = 16'd0; record_ticks = 16'd1; continuous = 1'b1;
    sync_in = 1'b0; enable = 1'b1;
    cyc(); cyc();
    sync_in = 1'b1;
    nk.delete(); ns.delete(); dk.delete(); first_rec = -1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (freq_step_out) begin nk.push_back(k); ns.push_back(int'(step_idx)); end
      if (sweep_done) dk.push_back(k);
      if (rx_record != 2'b00 && first_rec < 0) first_rec = k;
    end
    check("t2 first record", first_rec, 2);
    check("t2 next count", nk.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2 next_k[%0d]", i), (i < nk.size()) ? nk[i] : -1, 3 + 2 * i);
      check($sformatf("t2 next_step[%0d]", i), (i < ns.size()) ? ns[i] : -1, i % 2);
    end
    check("t2 done count", dk.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2 done_k[%0d]", i), (i < dk.size()) ? dk[i] : -1, 5 + 4 * i);

    // Re-sync at RECORD cycle 2 of step 3, then abort in SETTLE of step 5.
    enable = 1'b0; sync_in = 1'b0;
    cyc(); cyc();
    num_steps = 6'd6; settle_ticks = 16'd2; record_ticks = 16'd4; continuous = 1'b0;
    enable = 1'b1;
    cyc();
    sync_in = 1'b1;
    nk.delete(); ns.delete(); dk.delete(); extra_pulses = 0;
    for (int k = 1; k <= 66; k++) begin
      cyc();
      if (freq_step_out) begin nk.push_back(k); ns.push_back(int'(step_idx)); end
      if (k > 62 && (freq_step_out || rx_next != 2'b00 || sweep_done)) extra_pulses++;
      if (k == 26) begin
        check("t3 resync rx_reset", rx_reset, 2'b11);
        check("t3 resync no next", {rx_next, freq_step_out}, 3'd0);
        check("t3 resync step before", step_idx, 6'd3);
      end
      if (k == 27) begin
        check("t3 after step_idx", step_idx, 6'd0);
        check("t3 after sync_err", sync_err, 8'd1);
        check("t3 after rx_reset/busy", {rx_reset, busy}, 3'b001);
      end
      if (k == 28) check("t3 settle rx_record", rx_record, 2'b00);
      if (k == 29) check("t3 record rx_record", rx_record, 2'b11);
      if (k == 1) sync_in = 1'b0;
      if (k == 25) sync_in = 1'b1;
      if (k == 62) begin
        enable = 1'b0;
        #1;
        check("t5 abort busy", busy, 1'b0);
        check("t5 abort rx_record/next", {rx_record, rx_next, freq_step_out}, 5'd0);
      end
      if (k == 63) begin
        check("t5 idle rx_reset", rx_reset, 2'b11);
        check("t5 idle step held", step_idx, 6'd5);
      end
    end
    check("t5 no pulses after abort", extra_pulses, 0);
    check("t3 next count", nk.size(), 8);
    for (int i = 0; i < 8; i++) begin
      automatic int ek[8] = '{8, 15, 22, 33, 40, 47, 54, 61};
      automatic int es[8] = '{0, 1, 2, 0, 1, 2, 3, 4};
      check($sformatf("t3 next_k[%0d]", i), (i < nk.size()) ? nk[i] : -1, ek[i]);
      check($sformatf("t3 next_step[%0d]", i), (i < ns.size()) ? ns[i] : -1, es[i]);
    end
    enable = 1'b1; sync_in = 1'b0;
    cyc(); cyc();
    sync_in = 1'b1;
    cyc(); cyc();
    check("t5 restart step_idx", step_idx, 6'd0);
    check("t5 restart busy", busy, 1'b1);

    // Mask and clamp: mask 01, num_steps 0 then 40, continuous.
    enable = 1'b0; sync_in = 1'b0;
    cyc(); cyc();
    chan_mask = 2'b01;
    #1;
    check("t4 idle rx_reset", rx_reset, 2'b01);
    num_steps = 6'd0; settle_ticks = 16'd0; record_ticks = 16'd1; continuous = 1'b1;
    enable = 1'b1;
    cyc();
    sync_in = 1'b1;
    nk.delete(); dk.delete(); bad_bit1 = 0; max_step = 0;
    for (int k = 1; k <= 140; k++) begin
      cyc();
      if (k == 1) check("t4 arm rx_reset", rx_reset, 2'b01);
      if (k == 2) num_steps = 6'd40;
      if (freq_step_out && k <= 129) nk.push_back(k);
      if (freq_step_out) check($sformatf("t4 rx_next k%0d", k), rx_next, 2'b01);
      if (sweep_done) dk.push_back(k);
      if (rx_reset[1] || rx_next[1] || rx_record[1]) bad_bit1++;
      if (int'(step_idx) > max_step) max_step = int'(step_idx);
    end
    check("t4 bit1 activity", bad_bit1, 0);
    check("t4 max step", max_step, 31);
    check("t4 next count", nk.size(), 64);
    check("t4 done count", dk.size(), 2);
    check("t4 done_k[0]", (dk.size() > 0) ? dk[0] : -1, 65);
    check("t4 done_k[1]", (dk.size() > 1) ? dk[1] : -1, 129);

    // sync_err saturates at 255 under repeated re-syncs.
    for (int j = 0; j < 600; j++) begin
      sync_in = j[0];
      cyc();
    end
    check("sat sync_err", sync_err, 8'd255);

    // Timestamp of each RECORD start: settle 10, record 10 gives spacing 21.
    enable = 1'b0; sync_in = 1'b0;
    cyc(); cyc();
    chan_mask = 2'b11; num_steps = 6'd3; settle_ticks = 16'd10; record_ticks = 16'd10;
    continuous = 1'b0; enable = 1'b1;
    cyc();
    sync_in = 1'b1;
    ts.delete(); prev_rec = 2'b00;
    for (int k = 1; k <= 70; k++) begin
      cyc();
      if (rx_record[0] && !prev_rec[0]) ts.push_back(int'(rec_timestamp));
      prev_rec = rx_record;
    end
    check("t6 record starts", ts.size(), 3);
`ifdef FAST_SQUARE_TIMESTAMP_EN
    for (int i = 1; i < 3; i++)
      check($sformatf("t6 ts delta[%0d]", i), (i < ts.size()) ? ts[i] - ts[i-1] : -1, 21);
`else
    for (int i = 0; i < 3; i++)
      check($sformatf("t6 ts[%0d]", i), (i < ts.size()) ? ts[i] : -1, 0);
`endif
    check("t6 done busy", busy, 1'b0);
    check("t6 done step_idx", step_idx, 6'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fast_square_sweep_ctrl.md
Name: fast_square_sweep_ctrl

Overview:
- Parametrised successor to the fast-square frequency-step controller.
- Sequences a synthesiser frequency sweep: settle, record, advance. Drives reset/next/record strobes to up to NUM_CHAN fast_square_bb receive channels.
- Adds over the previous generation: runtime-programmable step count, record length and settle length; per-channel enable mask; single-shot or continuous mode; external re-sync detection.
- Sits in the RX side of the USRP top level on clk64. Programmed from setting_reg outputs; sync_in comes from the debounced daughterboard pin.

Parameters:
- NUM_FREQ_STEPS, 32, maximum steps per sweep; also used when num_steps=0.
- STEP_W, 6, width of num_steps and step_idx; must satisfy 2^STEP_W > NUM_FREQ_STEPS.
- TICK_W, 16, width of the record and settle counters.
- NUM_CHAN, 2, number of receive channels driven.

Ports:
- clock  in  1  clk64 domain clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; level-sensitive.
- continuous  in  1  1: wrap and re-sweep; 0: single sweep then DONE.
- num_steps  in  STEP_W  steps per sweep; 0 means NUM_FREQ_STEPS; values above NUM_FREQ_STEPS are clamped to NUM_FREQ_STEPS.
- record_ticks  in  TICK_W  record window in cycles; 0 is treated as 1.
- settle_ticks  in  TICK_W  settle window in cycles; 0 skips SETTLE.
- chan_mask  in  NUM_CHAN  channel enables; unmasked channels hold all rx_* outputs at 0.
- sync_in  in  1  debounced sweep-restart input; rising-edge sensitive.
- freq_step_out  out  1  1-cycle pulse telling the synthesiser to advance.
- rx_reset  out  NUM_CHAN  receiver accumulator reset.
- rx_next  out  NUM_CHAN  1-cycle pulse to store the result and advance the bin.
- rx_record  out  NUM_CHAN  level; high while recording.
- step_idx  out  STEP_W  current frequency index.
- busy  out  1  high in SETTLE, RECORD and NEXT.
- sweep_done  out  1  1-cycle pulse at the end of each sweep.
- sync_err  out  8  saturating count of mid-sweep re-syncs.
- rec_timestamp  out  32  see Optional Feature.

Behaviour:
- States: IDLE, ARM, SETTLE, RECORD, NEXT, DONE.
- Reset state: IDLE. On reset every output is 0 except rx_reset, which is all-ones for masked channels. Counters and sync_err clear. Latched configuration clears to 0.
- sync_in is registered once. rise = sync_q & ~sync_q_d.
- enable low in any state: IDLE on the next cycle. rx_record and busy drop that cycle. No rx_next or freq_step_out pulse is issued. step_idx is held.
- IDLE: rx_reset asserted for masked channels. enable=1 moves to ARM.
- ARM: waits for rise, with rx_reset still asserted. On rise:
  - latch num_steps, record_ticks, settle_ticks and chan_mask;
  - step_idx<=0;
  - go to SETTLE, or to RECORD if the latched settle_ticks=0.
  - rx_reset deasserts on the following cycle.
- SETTLE: counter loads settle_ticks-1 and counts down to 0, giving exactly settle_ticks cycles. Then RECORD.
- RECORD: rx_record high for exactly max(record_ticks,1) cycles. Then NEXT.
- NEXT (1 cycle): rx_next and freq_step_out pulse high together.
  - If step_idx == eff_steps-1 (last step), sweep_done pulses the same cycle.
    - continuous=1: step_idx<=0, configuration is re-latched, go to SETTLE/RECORD.
    - continuous=0: go to DONE, step_idx held.
  - Otherwise step_idx<=step_idx+1 and go to SETTLE/RECORD.
- DONE: busy=0. Stays until enable=0, then IDLE.
- rise during SETTLE, RECORD or NEXT is a re-sync:
  - pulse rx_reset for 1 cycle;
  - step_idx<=0; sync_err increments, saturating at 255;
  - restart SETTLE/RECORD;
  - no rx_next or freq_step_out pulse that cycle.
- rise in DONE is ignored. rise in IDLE is ignored.
- enable low and rise in the same cycle: enable wins.
- Configuration inputs are sampled only at latch points; mid-sweep changes have no effect until the next latch.
- Latencies: rise to first rx_record high = settle_ticks+2 cycles (2 cycles if settle_ticks=0). Last rx_record cycle to rx_next = 1 cycle.

Optional Feature:
- Macro: FAST_SQUARE_TIMESTAMP_EN.
- Defined: a 32-bit free-running cycle counter clears on reset and wraps. rec_timestamp captures it on the first cycle of each RECORD and holds until the next RECORD.
- Undefined: the counter is not built and rec_timestamp is tied to 0.

Test Plan:
- Single sweep: num_steps=4, settle=3, record=5, continuous=0, mask=2'b11, one sync rise. Expect 4 rx_next/freq_step_out pulses 9 cycles apart; step_idx 0→3; sweep_done on the 4th NEXT; then DONE with busy=0.
- Continuous wrap: num_steps=2, settle=0, record=1. Expect a NEXT every 2 cycles; step_idx toggling 0,1,0; sweep_done every 4 cycles.
- Mid-sweep re-sync: sync rise at RECORD cycle 2 of step 3. Expect a 1-cycle rx_reset pulse, step_idx=0, sync_err=1, no rx_next that cycle.
- Mask and clamp: chan_mask=2'b01, num_steps=0 and then 40, NUM_FREQ_STEPS=32. Expect rx_*[1]=0 throughout and 32 steps per sweep in both cases.
- Abort: enable dropped during SETTLE at step 5. Expect IDLE next cycle, rx_reset asserted, step_idx=5 held, no pulses; re-enable plus sync restarts from step 0.
- Timestamp (with FAST_SQUARE_TIMESTAMP_EN): settle=10, record=10. Consecutive rec_timestamp values differ by 21. Without the macro: rec_timestamp=0.
